// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: circular sample buffer with pre-trigger depth,
// masked level/edge trigger and an in-order sequential readout port.
module la_capture_core #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 9,
    parameter int TRIG_W     = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  arm_i,
    input  logic [DEPTH_LOG2-1:0] pretrig_i,
    input  logic [TRIG_W-1:0]     trig_mask_i,
    input  logic [TRIG_W-1:0]     trig_val_i,
    input  logic [TRIG_W-1:0]     trig_edge_i,
    input  logic [TRIG_W-1:0]     trig_i,
    input  logic [DATA_W-1:0]     data_i,
    output logic [1:0]            state_o,
    output logic                  triggered_o,
    output logic                  done_o,
    input  logic                  rd_req_i,
    output logic                  rd_valid_o,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic                  rd_last_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] addr_t;
    typedef logic [DEPTH_LOG2:0]   idx_t;

    localparam addr_t ADDR_ONE  = addr_t'(1);
    localparam addr_t LAST_ADDR = addr_t'(DEPTH - 1);
    localparam idx_t  IDX_ONE   = idx_t'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    addr_t             wr_ptr_q, wr_ptr_d;
    addr_t             cnt_q, cnt_d;
    addr_t             pretrig_q, pretrig_d;
    addr_t             base_q, base_d;
    logic [TRIG_W-1:0] mask_q, mask_d;
    logic [TRIG_W-1:0] val_q, val_d;
    logic [TRIG_W-1:0] edge_q, edge_d;
    logic [TRIG_W-1:0] trig_prev_q;
    logic              triggered_q, triggered_d;
    idx_t              rd_idx_q, rd_idx_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              wr_en;
    logic              rd_en;
    logic              fire;
    logic [TRIG_W-1:0] match;
    addr_t             pretrig_clamped;
    addr_t             rd_addr;

    // The pre-trigger depth can never exceed DEPTH-1 so that at least the trigger sample fits.
    assign pretrig_clamped = (32'(pretrig_i) > DEPTH - 1) ? LAST_ADDR : pretrig_i;

    assign match   = ~(trig_i ^ val_q) & (~edge_q | (trig_prev_q ^ val_q));
    assign fire    = &(~mask_q | match);
    assign rd_addr = base_q + rd_idx_q[DEPTH_LOG2-1:0];

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        pretrig_d   = pretrig_q;
        base_d      = base_q;
        mask_d      = mask_q;
        val_d       = val_q;
        edge_d      = edge_q;
        triggered_d = triggered_q;
        rd_idx_d    = rd_idx_q;
        rd_valid_d  = 1'b0;
        rd_last_d   = 1'b0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;

        if (arm_i) begin
            pretrig_d   = pretrig_clamped;
            mask_d      = trig_mask_i;
            val_d       = trig_val_i;
            edge_d      = trig_edge_i;
            wr_ptr_d    = '0;
            cnt_d       = '0;
            triggered_d = 1'b0;
            rd_idx_d    = '0;
            state_d     = (pretrig_clamped == '0) ? S_WAIT : S_PRE;
        end else begin
            unique case (state_q)
                S_PRE: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_ONE;
                    cnt_d    = cnt_q + ADDR_ONE;
                    if (cnt_q == pretrig_q - ADDR_ONE) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_ONE;
                    // The sample written on the firing cycle is the trigger sample.
                    if (fire) begin
                        triggered_d = 1'b1;
                        base_d      = wr_ptr_q - pretrig_q;
                        cnt_d       = LAST_ADDR - pretrig_q;
                        state_d     = (pretrig_q == LAST_ADDR) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_ONE;
                    cnt_d    = cnt_q - ADDR_ONE;
                    if (cnt_q == ADDR_ONE) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (rd_req_i && !rd_idx_q[DEPTH_LOG2]) begin
                        rd_en      = 1'b1;
                        rd_valid_d = 1'b1;
                        rd_last_d  = (rd_idx_q[DEPTH_LOG2-1:0] == LAST_ADDR);
                        rd_idx_d   = rd_idx_q + IDX_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            pretrig_q   <= '0;
            base_q      <= '0;
            mask_q      <= '0;
            val_q       <= '0;
            edge_q      <= '0;
            trig_prev_q <= '0;
            triggered_q <= 1'b0;
            rd_idx_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            pretrig_q   <= pretrig_d;
            base_q      <= base_d;
            mask_q      <= mask_d;
            val_q       <= val_d;
            edge_q      <= edge_d;
            trig_prev_q <= trig_i;
            triggered_q <= triggered_d;
            rd_idx_q    <= rd_idx_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            if (rd_en) begin
                rd_data_q <= mem_q[rd_addr];
            end
        end
    end

    // Sample RAM is deliberately left without reset so it maps onto block RAM.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_comb begin
        unique case (state_q)
            S_PRE:          state_o = 2'd1;
            S_WAIT, S_POST: state_o = 2'd2;
            S_DONE:         state_o = 2'd3;
            default:        state_o = 2'd0;
        endcase
    end

    assign triggered_o = triggered_q;
    assign done_o      = (state_q == S_DONE);
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign rd_last_o   = rd_last_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core: probe data is a free-running counter, so every
// expected readout word follows from the trigger sample value and the pre-trigger depth.
module tb_la_capture_core;

    localparam int DATA_W     = 8;
    localparam int DEPTH_LOG2 = 9;
    localparam int TRIG_W     = 4;
    localparam int DEPTH      = 512;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } rdExp_t;

    logic                  sysClk = 1'b0;
    logic                  sysRst;
    logic                  armIn;
    logic [DEPTH_LOG2-1:0] pretrigIn;
    logic [TRIG_W-1:0]     maskIn;
    logic [TRIG_W-1:0]     valIn;
    logic [TRIG_W-1:0]     edgeIn;
    logic [TRIG_W-1:0]     trigIn;
    logic [DATA_W-1:0]     dataIn;
    logic [1:0]            stateOut;
    logic                  triggeredOut;
    logic                  doneOut;
    logic                  rdReqIn;
    logic                  rdValidOut;
    logic [DATA_W-1:0]     rdDataOut;
    logic                  rdLastOut;

    rdExp_t            expQ[$];
    int                testsRun    = 0;
    int                testsFailed = 0;
    int                cycleCnt    = 0;
    int                readIdx     = 0;
    logic [DATA_W-1:0] trigData;

    always #5 sysClk = ~sysClk;

    la_capture_core #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .TRIG_W     (TRIG_W)
    ) dut (
        .sys_clk     (sysClk),
        .sys_rst     (sysRst),
        .arm_i       (armIn),
        .pretrig_i   (pretrigIn),
        .trig_mask_i (maskIn),
        .trig_val_i  (valIn),
        .trig_edge_i (edgeIn),
        .trig_i      (trigIn),
        .data_i      (dataIn),
        .state_o     (stateOut),
        .triggered_o (triggeredOut),
        .done_o      (doneOut),
        .rd_req_i    (rdReqIn),
        .rd_valid_o  (rdValidOut),
        .rd_data_o   (rdDataOut),
        .rd_last_o   (rdLastOut)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock: outputs are checked 1 ns after the edge, then the probe counter advances.
    task automatic step();
        rdExp_t e;
        @(posedge sysClk);
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("rd_valid", 32'(rdValidOut), 32'd1);
            checkOutput("rd_data", 32'(rdDataOut), 32'(e.data));
            checkOutput("rd_last", 32'(rdLastOut), 32'(e.last));
        end else begin
            checkOutput("no_rd_valid", 32'(rdValidOut), 32'd0);
        end
        cycleCnt++;
        dataIn = DATA_W'(cycleCnt);
    endtask

    task automatic applyStimulus(input int pre, input logic [TRIG_W-1:0] mask,
                                 input logic [TRIG_W-1:0] val, input logic [TRIG_W-1:0] edg);
        pretrigIn = DEPTH_LOG2'(pre);
        maskIn    = mask;
        valIn     = val;
        edgeIn    = edg;
        armIn     = 1'b1;
        readIdx   = 0;
        step();
        armIn     = 1'b0;
        checkOutput("arm_triggered_clear", 32'(triggeredOut), 32'd0);
        checkOutput("arm_done_clear", 32'(doneOut), 32'd0);
    endtask

    task automatic captureToDone(input int post);
        step();
        checkOutput("triggered", 32'(triggeredOut), 32'd1);
        if (post == 0) begin
            checkOutput("done_immediate", 32'(doneOut), 32'd1);
        end else begin
            repeat (post - 1) step();
            checkOutput("done_early", 32'(doneOut), 32'd0);
            checkOutput("state_post", 32'(stateOut), 32'd2);
            step();
            checkOutput("done", 32'(doneOut), 32'd1);
        end
        checkOutput("state_done", 32'(stateOut), 32'd3);
    endtask

    // Every request pushes the word it must return: counter value trigData - pre + index.
    task automatic readWords(input int n, input int pre);
        rdExp_t e;
        for (int i = 0; i < n; i++) begin
            rdReqIn = 1'b1;
            e.data  = DATA_W'(int'(trigData) - pre + readIdx);
            e.last  = (readIdx == DEPTH - 1);
            expQ.push_back(e);
            readIdx++;
            step();
        end
        rdReqIn = 1'b0;
        step();
    endtask

    task automatic readPastEnd();
        rdReqIn = 1'b1;
        step();
        step();
        rdReqIn = 1'b0;
        checkOutput("stay_done", 32'(doneOut), 32'd1);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sysRst    = 1'b1;
        armIn     = 1'b0;
        pretrigIn = '0;
        maskIn    = '0;
        valIn     = '0;
        edgeIn    = '0;
        trigIn    = '0;
        dataIn    = '0;
        rdReqIn   = 1'b0;

        // Reset release and ignored reads in IDLE.
        repeat (3) step();
        sysRst = 1'b0;
        step();
        checkOutput("rst_state", 32'(stateOut), 32'd0);
        checkOutput("rst_triggered", 32'(triggeredOut), 32'd0);
        checkOutput("rst_done", 32'(doneOut), 32'd0);
        checkOutput("rst_rd_last", 32'(rdLastOut), 32'd0);
        checkOutput("rst_rd_data", 32'(rdDataOut), 32'd0);
        rdReqIn = 1'b1;
        step();
        step();
        rdReqIn = 1'b0;

        // Level trigger on channel 0, 16 pre-trigger samples.
        applyStimulus(16, 4'b0001, 4'b0001, 4'b0000);
        checkOutput("pre_state", 32'(stateOut), 32'd1);
        repeat (15) step();
        checkOutput("pre_still", 32'(stateOut), 32'd1);
        step();
        checkOutput("wait_entered", 32'(stateOut), 32'd2);
        repeat (83) step();
        checkOutput("wait_no_fire", 32'(triggeredOut), 32'd0);
        trigIn   = 4'b0001;
        trigData = dataIn;
        captureToDone(DEPTH - 1 - 16);
        trigIn = '0;
        readWords(DEPTH, 16);
        readPastEnd();

        // Edge trigger: a level already at 1 must not fire, only a fresh rise.
        trigIn = 4'b0001;
        step();
        applyStimulus(4, 4'b0001, 4'b0001, 4'b0001);
        repeat (20) step();
        checkOutput("edge_held_state", 32'(stateOut), 32'd2);
        checkOutput("edge_held_no_fire", 32'(triggeredOut), 32'd0);
        trigIn = 4'b0000;
        step();
        checkOutput("edge_fall_no_fire", 32'(triggeredOut), 32'd0);
        trigIn   = 4'b0001;
        trigData = dataIn;
        captureToDone(DEPTH - 1 - 4);
        trigIn = '0;
        readWords(DEPTH, 4);

        // Masked AND: only bits [2:1] == 2'b10 matter.
        applyStimulus(8, 4'b0110, 4'b0100, 4'b0000);
        repeat (12) step();
        trigIn = 4'b1111;
        step();
        step();
        checkOutput("mask_11_no_fire", 32'(triggeredOut), 32'd0);
        trigIn = 4'b0011;
        step();
        step();
        checkOutput("mask_01_no_fire", 32'(triggeredOut), 32'd0);
        trigIn = 4'b1001;
        step();
        step();
        checkOutput("mask_00_no_fire", 32'(triggeredOut), 32'd0);
        trigIn   = 4'b1101;
        trigData = dataIn;
        captureToDone(DEPTH - 1 - 8);
        trigIn = '0;
        readWords(DEPTH, 8);

        // Zero pre-trigger: straight into WAIT, trigger sample is word 0.
        applyStimulus(0, 4'b0001, 4'b0001, 4'b0000);
        checkOutput("pre0_state", 32'(stateOut), 32'd2);
        repeat (5) step();
        trigIn   = 4'b0001;
        trigData = dataIn;
        captureToDone(DEPTH - 1);
        trigIn = '0;
        readWords(DEPTH, 0);

        // Maximum pre-trigger: trigger held during PRE is ignored, fires on the first WAIT cycle.
        applyStimulus(DEPTH - 1, 4'b0001, 4'b0001, 4'b0000);
        trigIn = 4'b0001;
        repeat (DEPTH - 1) step();
        checkOutput("premax_wait", 32'(stateOut), 32'd2);
        checkOutput("premax_ignored", 32'(triggeredOut), 32'd0);
        trigData = dataIn;
        captureToDone(0);
        trigIn = '0;
        readWords(DEPTH, DEPTH - 1);

        // Re-arm in the middle of POST restarts cleanly.
        applyStimulus(16, 4'b0001, 4'b0001, 4'b0000);
        repeat (30) step();
        trigIn = 4'b0001;
        repeat (11) step();
        checkOutput("rearm_in_post", 32'(stateOut), 32'd2);
        checkOutput("rearm_was_triggered", 32'(triggeredOut), 32'd1);
        trigIn = '0;
        applyStimulus(32, 4'b0001, 4'b0001, 4'b0000);
        checkOutput("rearm_state", 32'(stateOut), 32'd1);
        repeat (40) step();
        trigIn   = 4'b0001;
        trigData = dataIn;
        captureToDone(DEPTH - 1 - 32);
        trigIn = '0;
        readWords(10, 32);

        // Asynchronous reset in the middle of readout.
        rdReqIn = 1'b1;
        #2;
        sysRst = 1'b1;
        #1;
        checkOutput("async_rst_state", 32'(stateOut), 32'd0);
        checkOutput("async_rst_done", 32'(doneOut), 32'd0);
        checkOutput("async_rst_triggered", 32'(triggeredOut), 32'd0);
        checkOutput("async_rst_rd_valid", 32'(rdValidOut), 32'd0);
        step();
        sysRst = 1'b0;
        step();
        step();
        checkOutput("post_rst_state", 32'(stateOut), 32'd0);
        rdReqIn = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
